lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_load_extend.sv | 42 ++++
 rtl/lsu.sv | 160 ++++++++++++++++
 tb/tb_lsu.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: FSM state encodings, access-size
// codes and the funct3 load/store encodings used by the pipeline control.
package lsu_pkg;

  // Load/store funct3 encodings
  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;
  localparam logic [1:0] FNC_SB  = 2'b00;
  localparam logic [1:0] FNC_SH  = 2'b01;
  localparam logic [1:0] FNC_SW  = 2'b10;

  // Access-size classes (funct3[1:0] for both loads and stores)
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // LSU FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,  // no access outstanding
    S_REQ  = 2'b01,  // request presented, not yet accepted by the cache
    S_RESP = 2'b10   // load accepted, waiting for read data
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_extend.sv
// Load formatting: picks the byte or halfword at the given byte offset of a
// raw read word and sign- or zero-extends it according to the load funct3.
// Ports:
//   word      raw read word
//   offset    byte offset of the access within the word
//   ld_size   load funct3 (LB/LH/LW/LBU/LHU); other codes give zero
//   load_data formatted load result
module load_extend
  import lsu_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] word,
  input  logic [1:0]        offset,
  input  logic [2:0]        ld_size,
  output logic [DWIDTH-1:0] load_data
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    case (offset)
      2'd0:    sel_b = word[7:0];
      2'd1:    sel_b = word[15:8];
      2'd2:    sel_b = word[23:16];
      default: sel_b = word[31:24];
    endcase
    // Halfword loads are always 2-byte aligned, so only offset[1] matters.
    sel_h = offset[1] ? word[31:16] : word[15:0];

    case (ld_size)
      FNC_LB:  load_data = {{(DWIDTH-8){sel_b[7]}}, sel_b};
      FNC_LH:  load_data = {{(DWIDTH-16){sel_h[15]}}, sel_h};
      FNC_LW:  load_data = word;
      FNC_LBU: load_data = {{(DWIDTH-8){1'b0}}, sel_b};
      FNC_LHU: load_data = {{(DWIDTH-16){1'b0}}, sel_h};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the M stage and a ready/response data cache.
// A request is offered combinationally from IDLE; if the cache is not ready
// it is held in REQ from latched copies, and loads wait in RESP for the read
// strobe. Misaligned accesses are dropped with a one-cycle flag.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   mem_re, mem_we      M-stage load / store request (store wins)
//   addr, store_data    byte address, unshifted store value
//   st_size, ld_size    store funct3[1:0], load funct3
//   dcache_*            cache request (addr/din/we/req), handshake
//                       (ready), read data (dout) and read strobe (resp)
//   load_data           aligned, extended load result
//   stall_d             pipeline hold while an access is outstanding
//   misaligned          one-cycle flag for a rejected misaligned access
module lsu
  import lsu_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int WMASK  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [DWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] store_data,
  input  logic [1:0]        st_size,
  input  logic [2:0]        ld_size,
  output logic [DWIDTH-1:0] dcache_addr,
  output logic [DWIDTH-1:0] dcache_din,
  output logic [WMASK-1:0]  dcache_we,
  output logic              dcache_req,
  input  logic              dcache_ready,
  input  logic [DWIDTH-1:0] dcache_dout,
  input  logic              dcache_resp,
  output logic [DWIDTH-1:0] load_data,
  output logic              stall_d,
  output logic              misaligned
);

  function automatic logic [WMASK-1:0] store_mask(input logic [1:0] size,
                                                  input logic [1:0] off);
    case (size)
      SZ_BYTE: store_mask = WMASK'(1) << off;
      SZ_HALF: store_mask = WMASK'(3) << {off[1], 1'b0};
      SZ_WORD: store_mask = '1;
      default: store_mask = '0;
    endcase
  endfunction

  function automatic logic [DWIDTH-1:0] store_lanes(input logic [1:0] size,
                                                    input logic [DWIDTH-1:0] d);
    case (size)
      SZ_BYTE: store_lanes = {WMASK{d[7:0]}};
      SZ_HALF: store_lanes = {(WMASK/2){d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  lsu_state_e        state, state_nxt;
  logic              any_req, is_store, mis_chk, go;
  logic [1:0]        acc_size;
  logic [WMASK-1:0]  mask_in, mask_q;
  logic [DWIDTH-1:0] din_in, addr_q, data_q, resp_q;
  logic              st_q;
  logic [2:0]        ldsz_q, fmt_size_q;
  logic [1:0]        fmt_off_q;

  always_comb begin
    any_req  = mem_we | mem_re;
    is_store = mem_we;
    acc_size = mem_we ? st_size : ld_size[1:0];
    mis_chk  = ((acc_size == SZ_HALF) && addr[0]) ||
               ((acc_size == SZ_WORD) && (addr[1:0] != 2'b00));
    go       = (state == S_IDLE) && any_req && !mis_chk && !reset;
    mask_in  = store_mask(st_size, addr[1:0]);
    din_in   = store_lanes(st_size, store_data);
  end

  // Outputs and next state; everything is gated by reset so it takes effect
  // in the same cycle it is asserted.
  always_comb begin
    state_nxt   = state;
    dcache_req  = 1'b0;
    dcache_we   = '0;
    dcache_addr = {addr_q[DWIDTH-1:2], 2'b00};
    dcache_din  = data_q;
    stall_d     = 1'b0;
    misaligned  = 1'b0;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          dcache_addr = {addr[DWIDTH-1:2], 2'b00};
          dcache_din  = din_in;
          misaligned  = any_req && mis_chk;
          if (go) begin
            dcache_req = 1'b1;
            dcache_we  = is_store ? mask_in : '0;
            if (dcache_ready) begin
              state_nxt = is_store ? S_IDLE : S_RESP;
              stall_d   = !is_store;
            end else begin
              state_nxt = S_REQ;
              stall_d   = 1'b1;
            end
          end
        end
        S_REQ: begin
          dcache_req = 1'b1;
          dcache_we  = st_q ? mask_q : '0;
          stall_d    = 1'b1;
          if (dcache_ready) state_nxt = st_q ? S_IDLE : S_RESP;
        end
        S_RESP: begin
          stall_d = 1'b1;
          if (dcache_resp) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      st_q       <= 1'b0;
      ldsz_q     <= '0;
      resp_q     <= '0;
      fmt_off_q  <= '0;
      fmt_size_q <= '0;
    end else begin
      state <= state_nxt;
      if (go) begin
        addr_q <= addr;
        data_q <= din_in;
        mask_q <= mask_in;
        st_q   <= is_store;
        ldsz_q <= ld_size;
      end
      // Formatting info is captured with the data so a later store cannot
      // disturb the held load result.
      if (state == S_RESP && dcache_resp) begin
        resp_q     <= dcache_dout;
        fmt_off_q  <= addr_q[1:0];
        fmt_size_q <= ldsz_q;
      end
    end
  end

  load_extend #(.DWIDTH(DWIDTH)) u_load_extend (
    .word      (resp_q),
    .offset    (fmt_off_q),
    .ld_size   (fmt_size_q),
    .load_data (load_data)
  );

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_re, mem_we;
  logic [31:0] addr, store_data;
  logic [1:0]  st_size;
  logic [2:0]  ld_size;
  logic [31:0] dcache_addr, dcache_din;
  logic [3:0]  dcache_we;
  logic        dcache_req, dcache_ready, dcache_resp;
  logic [31:0] dcache_dout, load_data;
  logic        stall_d, misaligned;

  int total = 0;
  int bad   = 0;

  lsu #(.DWIDTH(32), .WMASK(4)) dut (
    .clk(clk), .reset(reset), .mem_re(mem_re), .mem_we(mem_we),
    .addr(addr), .store_data(store_data), .st_size(st_size), .ld_size(ld_size),
    .dcache_addr(dcache_addr), .dcache_din(dcache_din), .dcache_we(dcache_we),
    .dcache_req(dcache_req), .dcache_ready(dcache_ready),
    .dcache_dout(dcache_dout), .dcache_resp(dcache_resp),
    .load_data(load_data), .stall_d(stall_d), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load accepted immediately, read strobe one cycle later.
  task automatic do_load(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] w);
    mem_re = 1'b1; ld_size = sz; addr = a; dcache_ready = 1'b1;
    step();
    mem_re = 1'b0; dcache_ready = 1'b0; dcache_resp = 1'b1; dcache_dout = w;
    step();
    dcache_resp = 1'b0; dcache_dout = 32'h0;
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_re = 1'b0; mem_we = 1'b0; addr = 32'h0; store_data = 32'h0;
    st_size = 2'b00; ld_size = 3'b000; dcache_ready = 1'b0; dcache_dout = 32'h0;
    dcache_resp = 1'b0;
    step(); step();
    chk("rst_stall", {31'h0, stall_d}, 32'h0);
    chk("rst_req", {31'h0, dcache_req}, 32'h0);
    chk("rst_we", {28'h0, dcache_we}, 32'h0);
    chk("rst_mis", {31'h0, misaligned}, 32'h0);
    chk("rst_ld", load_data, 32'h0);
    reset = 1'b0;
    step();

    // SB to 0x1003, cache ready: single cycle, no stall
    mem_we = 1'b1; st_size = 2'b00; addr = 32'h1003; store_data = 32'h0000_00AB;
    dcache_ready = 1'b1;
    #1;
    chk("sb_req", {31'h0, dcache_req}, 32'h1);
    chk("sb_we", {28'h0, dcache_we}, 32'h8);
    chk("sb_din", dcache_din, 32'hABAB_ABAB);
    chk("sb_addr", dcache_addr, 32'h0000_1000);
    chk("sb_stall", {31'h0, stall_d}, 32'h0);
    step();
    mem_we = 1'b0; dcache_ready = 1'b0;
    #1;
    chk("sb_stall_after", {31'h0, stall_d}, 32'h0);
    chk("sb_req_after", {31'h0, dcache_req}, 32'h0);

    // LH at 0x2002, accepted at once, resp three cycles later
    mem_re = 1'b1; ld_size = 3'b001; addr = 32'h2002; dcache_ready = 1'b1;
    #1;
    chk("lh_req", {31'h0, dcache_req}, 32'h1);
    chk("lh_we", {28'h0, dcache_we}, 32'h0);
    chk("lh_addr", dcache_addr, 32'h0000_2000);
    chk("lh_stall_c0", {31'h0, stall_d}, 32'h1);
    step();
    mem_re = 1'b0; dcache_ready = 1'b0;
    #1;
    chk("lh_stall_c1", {31'h0, stall_d}, 32'h1);
    chk("lh_req_resp", {31'h0, dcache_req}, 32'h0);
    step();
    chk("lh_stall_c2", {31'h0, stall_d}, 32'h1);
    step();
    dcache_resp = 1'b1; dcache_dout = 32'h8001_1234;
    #1;
    chk("lh_stall_c3", {31'h0, stall_d}, 32'h1);
    step();
    dcache_resp = 1'b0; dcache_dout = 32'h0;
    #1;
    chk("lh_stall_c4", {31'h0, stall_d}, 32'h0);
    chk("lh_data", load_data, 32'hFFFF_8001);

    // Stray read strobe while idle must not disturb the held result
    dcache_resp = 1'b1; dcache_dout = 32'h1111_1111;
    step();
    dcache_resp = 1'b0;
    #1;
    chk("idle_resp_ignored", load_data, 32'hFFFF_8001);

    do_load(3'b100, 32'h2001, 32'h0000_F000);
    chk("lbu_data", load_data, 32'h0000_00F0);
    do_load(3'b000, 32'h2003, 32'h80FF_0000);
    chk("lb_data", load_data, 32'hFFFF_FF80);
    do_load(3'b010, 32'h6000, 32'hCAFE_F00D);
    chk("lw_data", load_data, 32'hCAFE_F00D);
    do_load(3'b011, 32'h6000, 32'h1234_5678);
    chk("unsup_data", load_data, 32'h0000_0000);
    do_load(3'b101, 32'h2002, 32'h8001_1234);
    chk("lhu_data", load_data, 32'h0000_8001);

    // Misaligned SW: flag only, no request, no stall
    mem_we = 1'b1; st_size = 2'b10; addr = 32'h3002; dcache_ready = 1'b1;
    #1;
    chk("sw_mis", {31'h0, misaligned}, 32'h1);
    chk("sw_mis_req", {31'h0, dcache_req}, 32'h0);
    chk("sw_mis_stall", {31'h0, stall_d}, 32'h0);
    chk("sw_mis_we", {28'h0, dcache_we}, 32'h0);
    step();
    mem_we = 1'b0; dcache_ready = 1'b0;
    #1;
    chk("sw_mis_pulse_end", {31'h0, misaligned}, 32'h0);

    // SH with simultaneous read (store wins), cache not ready for one cycle
    mem_we = 1'b1; mem_re = 1'b1; st_size = 2'b01; ld_size = 3'b010;
    addr = 32'h4002; store_data = 32'h1234_5678;
    #1;
    chk("sh_we", {28'h0, dcache_we}, 32'hC);
    chk("sh_din", dcache_din, 32'h5678_5678);
    chk("sh_stall", {31'h0, stall_d}, 32'h1);
    step();
    mem_we = 1'b0; addr = 32'h0000_9998; store_data = 32'h0;
    #1;
    chk("sh_hold_req", {31'h0, dcache_req}, 32'h1);
    chk("sh_hold_addr", dcache_addr, 32'h0000_4000);
    chk("sh_hold_we", {28'h0, dcache_we}, 32'hC);
    chk("sh_hold_din", dcache_din, 32'h5678_5678);
    dcache_ready = 1'b1;
    step();
    mem_re = 1'b0; dcache_ready = 1'b0;
    #1;
    chk("sh_done_stall", {31'h0, stall_d}, 32'h0);
    chk("sh_done_req", {31'h0, dcache_req}, 32'h0);
    chk("sh_ld_untouched", load_data, 32'h0000_8001);

    // LW held in REQ two cycles, then reset while waiting in RESP
    mem_re = 1'b1; ld_size = 3'b010; addr = 32'h5004; dcache_ready = 1'b0;
    step();
    mem_re = 1'b0; addr = 32'h0;
    #1;
    chk("lw_req_c1", {31'h0, dcache_req}, 32'h1);
    chk("lw_addr_c1", dcache_addr, 32'h0000_5004);
    step();
    chk("lw_req_c2", {31'h0, dcache_req}, 32'h1);
    chk("lw_addr_c2", dcache_addr, 32'h0000_5004);
    dcache_ready = 1'b1;
    step();
    dcache_ready = 1'b0;
    #1;
    chk("lw_resp_stall", {31'h0, stall_d}, 32'h1);
    reset = 1'b1;
    #1;
    chk("lw_rst_stall", {31'h0, stall_d}, 32'h0);
    chk("lw_rst_req", {31'h0, dcache_req}, 32'h0);
    chk("lw_rst_ld", load_data, 32'h0);
    step();
    reset = 1'b0;
    dcache_resp = 1'b1; dcache_dout = 32'hDEAD_BEEF;
    step();
    dcache_resp = 1'b0;
    #1;
    chk("late_resp_ld", load_data, 32'h0);
    chk("late_resp_stall", {31'h0, stall_d}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
